aes_input_loader: RTL and testbench
===================================

# aes_input_loader

Upstream feeder for the AES `Encrypt` core. It accepts 32-bit words over a valid/ready stream and assembles an `nk`-word cipher key followed by a 128-bit plaintext state. It then holds both as one block on a valid/ready output until the cipher side takes it. This block replaces the constant state/key assignments currently used to drive the cipher.

## Interface
Parameters:
- `nk`, 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` carries a valid word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `in_data`  in  32  key or state word, most-significant word first.
- `key_keep`  in  1  reuse the held key for the next block; port exists only with `KEY_REUSE_EN`.
- `out_valid`  out  1  `key_out` and `state_out` hold a complete block.
- `out_ready`  in  1  cipher side takes the block.
- `key_out`  out  nk*32  assembled key.
- `state_out`  out  128  assembled plaintext state.
- `blk_cnt`  out  16  count of blocks delivered; wraps modulo 2^16.

## Operation
- FSM states: `IDLE`, `LOAD_KEY`, `LOAD_STATE`, `HOLD`. Reset enters `IDLE`.
- `IDLE`: moves to `LOAD_KEY` on the next edge unconditionally.
- Word acceptance: a word is accepted on any edge where `in_valid && in_ready`.
- `in_ready` is 1 exactly in `LOAD_KEY` and `LOAD_STATE`.
- `word_cnt` (3 bits) indexes the word within the current field. It clears on every field change.
- `LOAD_KEY`:
  - Accepted word k (k = 0..nk-1) is written to `key_out[(nk-k)*32-1 -: 32]`.
  - After word nk-1 is accepted: go to `LOAD_STATE`.
- `LOAD_STATE`:
  - Accepted word s (s = 0..3) is written to `state_out[(4-s)*32-1 -: 32]`.
  - After word 3 is accepted: go to `HOLD`.
- `HOLD`:
  - `out_valid` is 1 and `key_out`/`state_out` are stable.
  - On `out_valid && out_ready`: `blk_cnt` increments (wraps from 0xFFFF to 0x0000) and the FSM goes to `LOAD_KEY`.
- `in_valid` low stalls loading indefinitely; no timeout.
- Words arriving in `HOLD` are not accepted because `in_ready` is 0.
- `out_ready` asserted outside `HOLD` has no effect.
- Output registers are never cleared between blocks. They are overwritten word by word as new words arrive.
- Reset mid-load or mid-hold:
  - The partial block is discarded.
  - All outputs return to their reset values.
  - Loading restarts with key word 0.

## Timing
- Reset values:
  - `in_ready` = 0, `out_valid` = 0.
  - `key_out` = 0, `state_out` = 0, `blk_cnt` = 0.
  - FSM = `IDLE`, `word_cnt` = 0.
- First edge after `rst_n` rises: FSM enters `LOAD_KEY`, so `in_ready` is 1 from the following cycle.
- Latency:
  - The final state word is accepted at edge N; `out_valid` is 1 immediately after edge N.
  - If `out_ready` is 1 in that cycle, the handshake occurs at edge N+1 and `in_ready` is 1 after edge N+1.
- Peak throughput: one block per nk+4+1 cycles. `in_valid` and `out_ready` held high gives 9 cycles/block for nk=4.
- All outputs are registered or decoded directly from the FSM state; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `KEY_REUSE_EN`.
- With `KEY_REUSE_EN` defined:
  - The `key_keep` port exists and is sampled at the output handshake edge.
  - If 1 and a key has been loaded since reset (internal `key_loaded` flag, set on completion of `LOAD_KEY`, cleared by reset), the next state is `LOAD_STATE` and `key_out` is retained. This gives 5 cycles/block.
  - If 1 and no key has been loaded yet, the FSM goes to `LOAD_KEY`.
- Without `KEY_REUSE_EN`:
  - No `key_keep` port and no `key_loaded` flag.
  - Every block loads the full key.

## Test plan
- Reset, then nk=4 words 00010203, 04050607, 08090a0b, 0c0d0e0f, then 00112233, 44556677, 8899aabb, ccddeeff with `in_valid`=1 -> after the 8th accept, `out_valid`=1, `key_out`=000102030405060708090a0b0c0d0e0f, `state_out`=00112233445566778899aabbccddeeff.
- Same stream with `out_ready` held 0 for 5 cycles -> `out_valid` stays 1, `in_ready` stays 0, outputs unchanged; when `out_ready` rises, `blk_cnt` 0->1 and `in_ready`=1 on the next cycle.
- nk=8, key 00010203..1c1d1e1f with random `in_valid` gaps -> `key_out`=000102...1f exactly; `in_ready` low only in `IDLE`/`HOLD`.
- Assert `rst_n`=0 after 3 key words -> `in_ready`=0, `key_out`=0, `blk_cnt`=0; after release, the next accepted word lands in `key_out[127:96]`.
- `KEY_REUSE_EN`: first block as above, handshake with `key_keep`=1, then 4 state words ffeeddcc, bbaa9988, 77665544, 33221100 -> `key_out` unchanged, `state_out`=ffeeddccbbaa99887766554433221100, `blk_cnt`=2.
- Preload `blk_cnt` to 0xFFFF via 65535 blocks (or force), deliver one more block -> `blk_cnt`=0x0000.

Source files
------------

// File: rtl/aes_input_loader_if.sv
`default_nettype none
// ============================================================================
// aes_input_loader_if : word input stream and assembled key/state block output
// Rev 1.0
// ============================================================================
interface aes_input_loader_if #(
  parameter int NK = 4
) ();
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [NK*32-1:0]  key_out;
  logic [127:0]      state_out;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, key_out, state_out
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, key_out, state_out
  );
endinterface
`default_nettype wire

// File: rtl/aes_input_loader.sv
`default_nettype none
// ============================================================================
// aes_input_loader : assembles an NK-word key and a 4-word state for AES.
// Optional macro KEY_REUSE_EN adds key_keep to skip reloading the key.
// Rev 1.0
// ============================================================================
module aes_input_loader #(
  parameter int NK = 4
) (
  input  wire                clk,
  input  wire                rst_n,
`ifdef KEY_REUSE_EN
  input  wire                key_keep,
`endif
  aes_input_loader_if.slave  bus,
  output logic [15:0]        blk_cnt
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_KEY   = 2'd1,
    LOAD_STATE = 2'd2,
    HOLD       = 2'd3
  } state_t;

  state_t           fsm_q, fsm_d;
  logic [2:0]       word_cnt_q, word_cnt_d;
  logic [NK*32-1:0] key_q, key_d;
  logic [127:0]     pt_q, pt_d;
  logic [15:0]      blk_cnt_q, blk_cnt_d;
  logic             in_ready;
  logic             accept;
`ifdef KEY_REUSE_EN
  logic             key_loaded_q, key_loaded_d;
`endif

  // Handshake outputs decode straight from the state register
  assign in_ready      = (fsm_q == LOAD_KEY) || (fsm_q == LOAD_STATE);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (fsm_q == HOLD);
  assign bus.key_out   = key_q;
  assign bus.state_out = pt_q;
  assign blk_cnt       = blk_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= IDLE;
      word_cnt_q   <= 3'd0;
      key_q        <= '0;
      pt_q         <= '0;
      blk_cnt_q    <= 16'd0;
`ifdef KEY_REUSE_EN
      key_loaded_q <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      word_cnt_q   <= word_cnt_d;
      key_q        <= key_d;
      pt_q         <= pt_d;
      blk_cnt_q    <= blk_cnt_d;
`ifdef KEY_REUSE_EN
      key_loaded_q <= key_loaded_d;
`endif
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    word_cnt_d   = word_cnt_q;
    key_d        = key_q;
    pt_d         = pt_q;
    blk_cnt_d    = blk_cnt_q;
`ifdef KEY_REUSE_EN
    key_loaded_d = key_loaded_q;
`endif
    case (fsm_q)
      IDLE: begin
        fsm_d      = LOAD_KEY;
        word_cnt_d = 3'd0;
      end
      LOAD_KEY: begin
        if (accept) begin
          // Word 0 is the most-significant word of the key
          for (int k = 0; k < NK; k++) begin
            if (word_cnt_q == 3'(k)) begin
              key_d[(NK-k)*32-1 -: 32] = bus.in_data;
            end
          end
          if (word_cnt_q == 3'(NK-1)) begin
            fsm_d        = LOAD_STATE;
            word_cnt_d   = 3'd0;
`ifdef KEY_REUSE_EN
            key_loaded_d = 1'b1;
`endif
          end else begin
            word_cnt_d = word_cnt_q + 3'd1;
          end
        end
      end
      LOAD_STATE: begin
        if (accept) begin
          for (int s = 0; s < 4; s++) begin
            if (word_cnt_q == 3'(s)) begin
              pt_d[(4-s)*32-1 -: 32] = bus.in_data;
            end
          end
          if (word_cnt_q == 3'd3) begin
            fsm_d      = HOLD;
            word_cnt_d = 3'd0;
          end else begin
            word_cnt_d = word_cnt_q + 3'd1;
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          blk_cnt_d  = blk_cnt_q + 16'd1;
          word_cnt_d = 3'd0;
          fsm_d      = LOAD_KEY;
`ifdef KEY_REUSE_EN
          if (key_keep && key_loaded_q) begin
            fsm_d = LOAD_STATE;
          end
`endif
        end
      end
      default: begin
        fsm_d      = IDLE;
        word_cnt_d = 3'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_input_loader.sv
`default_nettype none
// ============================================================================
// tb_aes_input_loader : directed self-checking bench for aes_input_loader
// Rev 1.0
// ============================================================================
module tb_aes_input_loader;

  logic        clk;
  logic        rst_n;
  logic [15:0] blk_cnt;
  logic [15:0] blk_cnt8;
  int          total;
  int          bad;
  int          exp_blk;
`ifdef KEY_REUSE_EN
  logic        key_keep;
  logic        key_keep8;
`endif

  aes_input_loader_if #(.NK(4)) bus ();
  aes_input_loader_if #(.NK(8)) bus8 ();

  aes_input_loader #(.NK(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef KEY_REUSE_EN
    .key_keep (key_keep),
`endif
    .bus      (bus),
    .blk_cnt  (blk_cnt)
  );

  aes_input_loader #(.NK(8)) dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
`ifdef KEY_REUSE_EN
    .key_keep (key_keep8),
`endif
    .bus      (bus8),
    .blk_cnt  (blk_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input logic [31:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL push_timeout in_ready=%0b required=1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hdeadbeef;
  endtask

  task automatic push8(input logic [31:0] d);
    int n;
    n = 0;
    bus8.in_valid = 1'b1;
    bus8.in_data  = d;
    while (!bus8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus8.in_ready) begin
      total++; bad++;
      $display("FAIL push8_timeout in_ready=%0b required=1", bus8.in_ready);
    end
    @(negedge clk);
    bus8.in_valid = 1'b0;
  endtask

  task automatic handshake();
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hs_pre_valid got=%0b exp=1", bus.out_valid); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_blk = (exp_blk + 1) % 65536;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL hs_post_valid got=%0b exp=0", bus.out_valid); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL hs_in_ready got=%0b exp=1", bus.in_ready); end
    total++;
    if (blk_cnt !== 16'(exp_blk)) begin bad++; $display("FAIL hs_blk_cnt got=%h exp=%h", blk_cnt, 16'(exp_blk)); end
  endtask

  task automatic push_block(input logic [127:0] k, input logic [127:0] s);
    for (int i = 3; i >= 0; i--) push(k[i*32 +: 32]);
    for (int i = 3; i >= 0; i--) push(s[i*32 +: 32]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.key_out !== 128'h0) begin bad++; $display("FAIL rst_key got=%h exp=0", bus.key_out); end
    total++; if (bus.state_out !== 128'h0) begin bad++; $display("FAIL rst_state got=%h exp=0", bus.state_out); end
    total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL rst_blk_cnt got=%h exp=0", blk_cnt); end
    rst_n = 1'b1;
    exp_blk = 0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL idle_in_ready got=%0b exp=0", bus.in_ready); end
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL first_load_ready got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_block();
    push_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL blk_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL blk_in_ready got=%0b exp=0", bus.in_ready); end
    total++; if (bus.key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin bad++; $display("FAIL blk_key got=%h", bus.key_out); end
    total++; if (bus.state_out !== 128'h00112233445566778899aabbccddeeff) begin bad++; $display("FAIL blk_state got=%h", bus.state_out); end
    total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL blk_cnt_early got=%h exp=0", blk_cnt); end
  endtask

  task automatic test_hold();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h55aa55aa;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d] got=%0b exp=1", i, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d] got=%0b exp=0", i, bus.in_ready); end
      total++; if (bus.key_out !== 128'h000102030405060708090a0b0c0d0e0f || bus.state_out !== 128'h00112233445566778899aabbccddeeff) begin
        bad++; $display("FAIL hold_data[%0d] key=%h state=%h", i, bus.key_out, bus.state_out);
      end
      total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL hold_blk_cnt[%0d] got=%h exp=0", i, blk_cnt); end
    end
    bus.in_valid = 1'b0;
    handshake();
  endtask

  task automatic test_out_ready_outside_hold();
    bus.out_ready = 1'b1;
    push(32'h0f0e0d0c); push(32'h0b0a0908); push(32'h07060504); push(32'h03020100);
    total++; if (blk_cnt !== 16'(exp_blk)) begin bad++; $display("FAIL early_ready_cnt got=%h exp=%h", blk_cnt, 16'(exp_blk)); end
    bus.out_ready = 1'b0;
    push(32'hffeeddcc); push(32'hbbaa9988); push(32'h77665544); push(32'h33221100);
    total++; if (bus.key_out !== 128'h0f0e0d0c0b0a09080706050403020100) begin bad++; $display("FAIL blk2_key got=%h", bus.key_out); end
    total++; if (bus.state_out !== 128'hffeeddccbbaa99887766554433221100) begin bad++; $display("FAIL blk2_state got=%h", bus.state_out); end
    handshake();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 18; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_data   = 32'h100 + 32'(i);
      @(negedge clk);
      if (i == 8) begin
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid8 got=%0b exp=1", bus.out_valid); end
      end
      if (i == 9) begin
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_after_hs valid=%0b ready=%0b exp 0/1", bus.out_valid, bus.in_ready);
        end
      end
      if (i == 16) begin
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid16 got=%0b exp=0", bus.out_valid); end
      end
      if (i == 17) begin
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid17 got=%0b exp=1", bus.out_valid); end
        total++; if (bus.key_out !== 128'h0000010a0000010b0000010c0000010d) begin bad++; $display("FAIL b2b_key got=%h", bus.key_out); end
        total++; if (bus.state_out !== 128'h0000010e0000010f0000011000000111) begin bad++; $display("FAIL b2b_state got=%h", bus.state_out); end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_blk += 2;
    total++; if (blk_cnt !== 16'(exp_blk)) begin bad++; $display("FAIL b2b_blk_cnt got=%h exp=%h", blk_cnt, 16'(exp_blk)); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_end_ready got=%0b exp=1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_load();
    push(32'h11111111); push(32'h22222222); push(32'h33333333);
    rst_n = 1'b0;
    #1;
    exp_blk = 0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%0b exp=0", bus.in_ready); end
    total++; if (bus.key_out !== 128'h0) begin bad++; $display("FAIL mid_rst_key got=%h exp=0", bus.key_out); end
    total++; if (blk_cnt !== 16'h0) begin bad++; $display("FAIL mid_rst_cnt got=%h exp=0", blk_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(32'haabbccdd);
    total++; if (bus.key_out[127:96] !== 32'haabbccdd) begin bad++; $display("FAIL mid_rst_word0 got=%h exp=aabbccdd", bus.key_out[127:96]); end
    total++; if (bus.key_out[95:0] !== 96'h0) begin bad++; $display("FAIL mid_rst_rest got=%h exp=0", bus.key_out[95:0]); end
    push(32'h1); push(32'h2); push(32'h3);
    push(32'h4); push(32'h5); push(32'h6); push(32'h7);
    total++; if (bus.state_out !== 128'h00000004000000050000000600000007) begin bad++; $display("FAIL mid_rst_state got=%h", bus.state_out); end
    handshake();
  endtask

  task automatic test_nk8();
    logic [255:0] k;
    int gap;
    for (int i = 0; i < 8; i++) begin
      k = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL nk8_gap_ready got=%0b exp=1", bus8.in_ready); end
      end
      push8(k[31:0]);
    end
    push8(32'h00112233); push8(32'h44556677);
    @(negedge clk);
    total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL nk8_state_ready got=%0b exp=1", bus8.in_ready); end
    push8(32'h8899aabb); push8(32'hccddeeff);
    total++; if (bus8.key_out !== 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f) begin
      bad++; $display("FAIL nk8_key got=%h", bus8.key_out);
    end
    total++; if (bus8.state_out !== 128'h00112233445566778899aabbccddeeff) begin bad++; $display("FAIL nk8_state got=%h", bus8.state_out); end
    total++; if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0) begin
      bad++; $display("FAIL nk8_hold valid=%0b ready=%0b exp 1/0", bus8.out_valid, bus8.in_ready);
    end
    bus8.out_ready = 1'b1;
    @(negedge clk);
    bus8.out_ready = 1'b0;
    total++; if (blk_cnt8 !== 16'h1 || bus8.in_ready !== 1'b1) begin
      bad++; $display("FAIL nk8_hs cnt=%h ready=%0b exp 0001/1", blk_cnt8, bus8.in_ready);
    end
  endtask

`ifdef KEY_REUSE_EN
  task automatic test_key_reuse();
    push_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    key_keep      = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    key_keep      = 1'b0;
    bus.out_ready = 1'b0;
    exp_blk = (exp_blk + 1) % 65536;
    push(32'hffeeddcc); push(32'hbbaa9988); push(32'h77665544); push(32'h33221100);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL reuse_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin bad++; $display("FAIL reuse_key got=%h", bus.key_out); end
    total++; if (bus.state_out !== 128'hffeeddccbbaa99887766554433221100) begin bad++; $display("FAIL reuse_state got=%h", bus.state_out); end
    handshake();
  endtask
`endif

  task automatic test_wrap();
    push_block(128'h0123456789abcdef0123456789abcdef, 128'hfedcba9876543210fedcba9876543210);
    force dut.blk_cnt_q = 16'hffff;
    @(posedge clk);
    #1;
    release dut.blk_cnt_q;
    @(negedge clk);
    exp_blk = 16'hffff;
    total++; if (blk_cnt !== 16'hffff) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", blk_cnt); end
    handshake();
    total++; if (blk_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", blk_cnt); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp_blk = 0;
    rst_n = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_data    = 32'h0;
    bus.out_ready  = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.in_data   = 32'h0;
    bus8.out_ready = 1'b0;
`ifdef KEY_REUSE_EN
    key_keep  = 1'b0;
    key_keep8 = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_block();
    test_hold();
    test_out_ready_outside_hold();
    test_back_to_back();
    test_reset_mid_load();
    test_nk8();
`ifdef KEY_REUSE_EN
    test_key_reuse();
`endif
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
